// File: rtl/rvx_core_store_sequencer_if.sv
// Store-side request/status and data-bus write channel of the store sequencer.
// The master modport is the sequencer's view; slave is the pipeline/bus side.
interface rvx_core_store_sequencer_if;
  logic        store_request;
  logic [31:0] store_address;
  logic [31:0] store_data;
  logic [2:0]  store_funct3;
  logic        store_busy;
  logic        store_done;
  logic        store_misaligned;
  logic [31:0] dbus_address;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrobe;
  logic        dbus_wrequest;
  logic        dbus_ready;

  modport master (
    input  store_request, store_address, store_data, store_funct3, dbus_ready,
    output store_busy, store_done, store_misaligned,
    output dbus_address, dbus_wdata, dbus_wstrobe, dbus_wrequest
  );

  modport slave (
    output store_request, store_address, store_data, store_funct3, dbus_ready,
    input  store_busy, store_done, store_misaligned,
    input  dbus_address, dbus_wdata, dbus_wstrobe, dbus_wrequest
  );
endinterface

// File: rtl/rvx_core_store_sequencer.sv
// Store bus sequencer: turns one store into one or two word-aligned write beats,
// splitting stores that straddle a word boundary. All outputs are registered.
module rvx_core_store_sequencer #(
  parameter bit SPLIT_ENABLE = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  rvx_core_store_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;

  state_e      state_q, state_d;
  logic [29:0] word_q, word_d;
  logic [7:0]  mask_q, mask_d;
  logic [63:0] data_q, data_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        wreq_q, wreq_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;

  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [7:0]  req_mask;
  logic [63:0] req_data;
  logic        req_split;
  logic        req_take;
  logic        unused_funct3;

  assign unused_funct3 = bus.store_funct3[2];

  // Lane math on the incoming request: an 8-lane window covering two words.
  always_comb begin
    off = bus.store_address[1:0];
    case (bus.store_funct3[1:0])
      2'b00:   size_mask = 4'h1;
      2'b01:   size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase
    req_mask  = {4'b0000, size_mask} << off;
    req_data  = {32'b0, bus.store_data} << {off, 3'b000};
    req_split = |req_mask[7:4];
    req_take  = (state_q == IDLE) && bus.store_request && (SPLIT_ENABLE || !req_split);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      wreq_q  <= wreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_take) begin
          state_d = BEAT1;
          word_d  = bus.store_address[31:2];
          mask_d  = req_mask;
          data_d  = req_data;
        end
      end
      BEAT1: begin
        if (bus.dbus_ready) state_d = (|mask_q[7:4]) ? BEAT2 : IDLE;
      end
      BEAT2: begin
        if (bus.dbus_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    strb_d  = '0;
    wreq_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_q != IDLE) && (state_d == IDLE);
    mis_d   = (state_q == IDLE) && bus.store_request && req_split && !SPLIT_ENABLE;
    case (state_d)
      BEAT1: begin
        wreq_d  = 1'b1;
        addr_d  = {word_d, 2'b00};
        strb_d  = mask_d[3:0];
        wdata_d = data_d[31:0];
      end
      BEAT2: begin
        wreq_d  = 1'b1;
        addr_d  = {word_d + 30'd1, 2'b00};
        strb_d  = mask_d[7:4];
        wdata_d = data_d[63:32];
      end
      default: ;
    endcase
  end

  assign bus.dbus_address     = addr_q;
  assign bus.dbus_wdata       = wdata_q;
  assign bus.dbus_wstrobe     = strb_q;
  assign bus.dbus_wrequest    = wreq_q;
  assign bus.store_busy       = busy_q;
  assign bus.store_done       = done_q;
  assign bus.store_misaligned = mis_q;

endmodule

// File: tb/tb_rvx_core_store_sequencer.sv
// Directed bench: split-enabled and split-disabled sequencers side by side.
module tb_rvx_core_store_sequencer;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_bad;

  rvx_core_store_sequencer_if sif();
  rvx_core_store_sequencer_if rif();

  rvx_core_store_sequencer #(.SPLIT_ENABLE(1'b1)) u_split (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  rvx_core_store_sequencer #(.SPLIT_ENABLE(1'b0)) u_nosplit (
    .clock (clock),
    .reset (reset),
    .bus   (rif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] w,
                          input logic [3:0] s);
    chk({tag, ".wreq"}, 32'(sif.dbus_wrequest), 32'd1);
    chk({tag, ".busy"}, 32'(sif.store_busy), 32'd1);
    chk({tag, ".done"}, 32'(sif.store_done), 32'd0);
    chk({tag, ".addr"}, sif.dbus_address, a);
    chk({tag, ".strb"}, 32'(sif.dbus_wstrobe), 32'(s));
    chk({tag, ".wdat"}, sif.dbus_wdata, w);
  endtask

  // Issue one store on the split-enabled unit; each beat waits 'waits' cycles.
  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, input int waits, input logic two,
                           input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] s1,
                           input logic [31:0] a2, input logic [31:0] w2, input logic [3:0] s2);
    sif.store_request = 1'b1;
    sif.store_address = a;
    sif.store_data    = d;
    sif.store_funct3  = f3;
    sif.dbus_ready    = 1'b0;
    cyc();
    sif.store_request = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      chk_beat({tag, ".b1"}, a1, w1, s1);
      sif.dbus_ready = (k == waits);
      cyc();
    end
    if (two) begin
      for (int k = 0; k <= waits; k++) begin
        chk_beat({tag, ".b2"}, a2, w2, s2);
        sif.dbus_ready = (k == waits);
        cyc();
      end
    end
    sif.dbus_ready = 1'b0;
    chk({tag, ".done"}, 32'(sif.store_done), 32'd1);
    chk({tag, ".idle"}, 32'(sif.store_busy), 32'd0);
    chk({tag, ".wreq0"}, 32'(sif.dbus_wrequest), 32'd0);
    chk({tag, ".strb0"}, 32'(sif.dbus_wstrobe), 32'd0);
    chk({tag, ".wdat0"}, sif.dbus_wdata, 32'd0);
    cyc();
    chk({tag, ".pulse"}, 32'(sif.store_done), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    sif.store_request = 1'b0; sif.store_address = '0; sif.store_data = '0;
    sif.store_funct3  = '0;   sif.dbus_ready    = 1'b0;
    rif.store_request = 1'b0; rif.store_address = '0; rif.store_data = '0;
    rif.store_funct3  = '0;   rif.dbus_ready    = 1'b1;
    cyc();
    cyc();

    chk("rst.wreq", 32'(sif.dbus_wrequest), 32'd0);
    chk("rst.busy", 32'(sif.store_busy), 32'd0);
    chk("rst.done", 32'(sif.store_done), 32'd0);
    chk("rst.mis",  32'(rif.store_misaligned), 32'd0);
    chk("rst.addr", sif.dbus_address, 32'd0);
    chk("rst.strb", 32'(sif.dbus_wstrobe), 32'd0);
    chk("rst.wdat", sif.dbus_wdata, 32'd0);
    reset = 1'b0;
    cyc();

    run_store("sw_al", 32'h100, 32'hDEADBEEF, 3'b010, 0, 1'b0,
              32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h0, 4'b0000);
    run_store("sb_o3", 32'h203, 32'h000000AB, 3'b000, 0, 1'b0,
              32'h200, 32'hAB000000, 4'b1000, 32'h0, 32'h0, 4'b0000);
    run_store("sh_o2", 32'h202, 32'h00001234, 3'b001, 0, 1'b0,
              32'h200, 32'h12340000, 4'b1100, 32'h0, 32'h0, 4'b0000);
    run_store("sh_o1", 32'h101, 32'h0000ABCD, 3'b001, 0, 1'b0,
              32'h100, 32'h00ABCD00, 4'b0110, 32'h0, 32'h0, 4'b0000);
    run_store("sw_f7", 32'h010, 32'h01020304, 3'b111, 1, 1'b0,
              32'h010, 32'h01020304, 4'b1111, 32'h0, 32'h0, 4'b0000);
    run_store("sw_o1", 32'h101, 32'h11223344, 3'b010, 0, 1'b1,
              32'h100, 32'h22334400, 4'b1110, 32'h104, 32'h00000011, 4'b0001);
    run_store("sh_wrap", 32'hFFFFFFFF, 32'h0000BEEF, 3'b001, 2, 1'b1,
              32'hFFFFFFFC, 32'hEF000000, 4'b1000, 32'h0, 32'h000000BE, 4'b0001);

    // Request held high while busy is ignored, then taken in the done cycle.
    sif.store_request = 1'b1; sif.store_address = 32'h001; sif.store_data = 32'h55;
    sif.store_funct3  = 3'b000; sif.dbus_ready = 1'b1;
    cyc();
    chk_beat("b2b.1", 32'h000, 32'h00005500, 4'b0010);
    sif.store_address = 32'h00C; sif.store_data = 32'h77;
    cyc();
    chk("b2b.done", 32'(sif.store_done), 32'd1);
    chk("b2b.busy", 32'(sif.store_busy), 32'd0);
    cyc();
    sif.store_request = 1'b0;
    chk_beat("b2b.2", 32'h00C, 32'h00000077, 4'b0001);
    cyc();
    chk("b2b.done2", 32'(sif.store_done), 32'd1);
    sif.dbus_ready = 1'b0;
    cyc();

    // Reset during a stalled first beat.
    sif.store_request = 1'b1; sif.store_address = 32'h300; sif.store_data = 32'hA5A5A5A5;
    sif.store_funct3  = 3'b010;
    cyc();
    sif.store_address = 32'h400; sif.store_data = 32'h0;
    cyc();
    chk_beat("rmid.hold", 32'h300, 32'hA5A5A5A5, 4'b1111);
    sif.store_request = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rmid.wreq", 32'(sif.dbus_wrequest), 32'd0);
    chk("rmid.busy", 32'(sif.store_busy), 32'd0);
    chk("rmid.done", 32'(sif.store_done), 32'd0);
    cyc();
    chk("rmid.done2", 32'(sif.store_done), 32'd0);
    chk("rmid.wreq2", 32'(sif.dbus_wrequest), 32'd0);

    // Split disabled: misaligned word rejected, next aligned one taken at once.
    rif.store_request = 1'b1; rif.store_address = 32'h102; rif.store_data = 32'h99887766;
    rif.store_funct3  = 3'b010;
    cyc();
    chk("mis.pulse", 32'(rif.store_misaligned), 32'd1);
    chk("mis.wreq",  32'(rif.dbus_wrequest), 32'd0);
    chk("mis.busy",  32'(rif.store_busy), 32'd0);
    chk("mis.done",  32'(rif.store_done), 32'd0);
    rif.store_address = 32'h104; rif.store_data = 32'hCAFEF00D;
    cyc();
    rif.store_request = 1'b0;
    chk("mis.clr",  32'(rif.store_misaligned), 32'd0);
    chk("mis.nwrq", 32'(rif.dbus_wrequest), 32'd1);
    chk("mis.addr", rif.dbus_address, 32'h104);
    chk("mis.strb", 32'(rif.dbus_wstrobe), 32'hF);
    chk("mis.wdat", rif.dbus_wdata, 32'hCAFEF00D);
    cyc();
    chk("mis.ndone", 32'(rif.store_done), 32'd1);
    chk("mis.nbusy", 32'(rif.store_busy), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
